// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/writeback stage of the pipelined RV32I core.
// This stage accepts instructions from the memory stage. For loads it waits
// for the data-memory read response, then formats the loaded data. It drives
// a registered one-cycle register-file write strobe, the write-back
// instruction word and the write data.
// Optional feature: define WB_RETIRE_CNT_EN to add a 64-bit retired-instruction
// counter on output port instret.
module mem_wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] inst_M,
    input  logic [XLEN-1:0] alu_M,
    input  logic [XLEN-1:0] pc_M,
    input  logic [1:0]      wb_sel_M,
    input  logic            reg_wen_M,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            RegWEn,
    output logic [XLEN-1:0] inst_W,
    output logic [XLEN-1:0] DataD
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]     instret
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t      state;
    state_t      state_next;

    // A pending load needs only its instruction word, its byte offset and its
    // write enable. The PC and the upper address bits play no part in a load
    // writeback, so they are not kept.
    logic [31:0] cap_inst;
    logic [1:0]  cap_off;
    logic        cap_wen;

    logic        retire;
    logic        capture_load;
    logic [31:0] next_inst;
    logic [31:0] next_data;
    logic        next_wen;

    // Select the byte or halfword from the word-aligned read data.
    // Sign- or zero-extend it according to funct3.
    function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b100:  fmt_load = {24'h000000, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b101:  fmt_load = {16'h0000, h};
            default: fmt_load = word;
        endcase
    endfunction

    // Next-state, handshake and next writeback values. in_ready depends only on state.
    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        retire       = 1'b0;
        capture_load = 1'b0;
        next_inst    = inst_W;
        next_data    = DataD;
        next_wen     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (wb_sel_M == 2'd1) begin
                        capture_load = 1'b1;
                        state_next   = WAIT_MEM;
                    end else begin
                        retire    = 1'b1;
                        next_inst = inst_M;
                        next_wen  = reg_wen_M && (inst_M[11:7] != 5'd0);
                        next_data = (wb_sel_M == 2'd2) ? (pc_M + 32'd4) : alu_M;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    retire     = 1'b1;
                    next_inst  = cap_inst;
                    next_wen   = cap_wen && (cap_inst[11:7] != 5'd0);
                    next_data  = fmt_load(cap_inst[14:12], cap_off, mem_rdata);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register. Reset drops any pending load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Hold the accepted load until its memory response arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_inst <= NOP;
            cap_off  <= 2'b00;
            cap_wen  <= 1'b0;
        end else if (capture_load) begin
            cap_inst <= inst_M;
            cap_off  <= alu_M[1:0];
            cap_wen  <= reg_wen_M;
        end
    end

    // Registered writeback outputs. They update only on a retire edge, and
    // the strobe stays high for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWEn <= 1'b0;
            inst_W <= NOP;
            DataD  <= 32'h0000_0000;
        end else begin
            RegWEn <= next_wen;
            if (retire) begin
                inst_W <= next_inst;
                DataD  <= next_data;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Count every retire, including rd = 0 retires. The counter wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         instret <= 64'd0;
        else if (retire) instret <= instret + 64'd1;
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: testbench for mem_wb_stage. It applies directed table
// vectors, hand-written multi-cycle sequences and randomized traffic, and
// compares the outputs against a behavioural model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst_M;
    logic [31:0] alu_M;
    logic [31:0] pc_M;
    logic [1:0]  wb_sel_M;
    logic        reg_wen_M;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        RegWEn;
    logic [31:0] inst_W;
    logic [31:0] DataD;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] instret;
`endif

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .inst_M(inst_M),
        .alu_M(alu_M),
        .pc_M(pc_M),
        .wb_sel_M(wb_sel_M),
        .reg_wen_M(reg_wen_M),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .RegWEn(RegWEn),
        .inst_W(inst_W),
        .DataD(DataD)
`ifdef WB_RETIRE_CNT_EN
        ,
        .instret(instret)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [1:0]  sel;
        logic        wen;
        int          delay;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_wen;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] inst,
                                 input logic [31:0] alu, input logic [31:0] pc,
                                 input logic [1:0] sel, input logic wen,
                                 input logic rv, input logic [31:0] rdata);
        in_valid   = v;
        inst_M     = inst;
        alu_M      = alu;
        pc_M       = pc;
        wb_sel_M   = sel;
        reg_wen_M  = wen;
        mem_rvalid = rv;
        mem_rdata  = rdata;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference load formatting, computed with shifts and modular arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [31:0] addr,
                                             input logic [31:0] word);
        longint unsigned w;
        longint          v;
        int              off;
        w   = word;
        off = int'(addr % 4);
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = longint'((w >> (8 * off)) % 256);
            if (f3 == 3'd0 && v >= 128) v = v - 256;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = longint'((w >> (16 * (off / 2))) % 65536);
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(w);
        end
        return 32'(v);
    endfunction

    vec_t vecs[$];

    // Behavioural model state for the random phase.
    bit          m_busy;
    logic [31:0] m_pinst;
    logic [31:0] m_palu;
    logic        m_pwen;
    logic [31:0] m_inst_w;
    logic [31:0] m_data;
    logic        m_wen;
    longint unsigned m_cnt;

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("reset_RegWEn", RegWEn, 1'b0);
        checkOutput("reset_inst_W", inst_W, 32'h0000_0013);
        checkOutput("reset_DataD", DataD, 32'h0);
        checkOutput("reset_in_ready", in_ready, 1'b1);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("reset_instret", instret, 64'd0);
`endif
        tick();
        tick();
        rst = 1'b0;

        // Directed vectors: inst, alu, pc, sel, wen, rvalid delay, rdata, expected DataD, expected RegWEn.
        vecs.push_back('{32'h00A302B3, 32'h0000_0007, 32'h0000_0100, 2'd0, 1'b1, 0, 32'h0, 32'h0000_0007, 1'b1});
        vecs.push_back('{32'h00000303, 32'h0000_1003, 32'h0000_0104, 2'd1, 1'b1, 3, 32'h80FF1234, 32'hFFFF_FF80, 1'b1});
        vecs.push_back('{32'h00004303, 32'h0000_1003, 32'h0000_0108, 2'd1, 1'b1, 3, 32'h80FF1234, 32'h0000_0080, 1'b1});
        vecs.push_back('{32'h00005383, 32'h0000_2002, 32'h0000_010C, 2'd1, 1'b1, 1, 32'hBEEF0000, 32'h0000_BEEF, 1'b1});
        vecs.push_back('{32'h00001383, 32'h0000_2002, 32'h0000_0110, 2'd1, 1'b1, 2, 32'hBEEF0000, 32'hFFFF_BEEF, 1'b1});
        vecs.push_back('{32'h000000EF, 32'h1234_5678, 32'hFFFF_FFFC, 2'd2, 1'b1, 0, 32'h0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h00000033, 32'h0000_0005, 32'h0000_0114, 2'd0, 1'b1, 0, 32'h0, 32'h0000_0005, 1'b0});
        vecs.push_back('{32'h00000303, 32'h0000_1000, 32'h0000_0118, 2'd1, 1'b1, 1, 32'h80FF1234, 32'h0000_0034, 1'b1});
        vecs.push_back('{32'h00000303, 32'h0000_1001, 32'h0000_011C, 2'd1, 1'b1, 1, 32'h80FF1234, 32'h0000_0012, 1'b1});
        vecs.push_back('{32'h00000303, 32'h0000_1002, 32'h0000_0120, 2'd1, 1'b1, 1, 32'h80FF1234, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{32'h00001383, 32'h0000_2001, 32'h0000_0124, 2'd1, 1'b1, 1, 32'h12348765, 32'hFFFF_8765, 1'b1});
        vecs.push_back('{32'h00005383, 32'h0000_2003, 32'h0000_0128, 2'd1, 1'b1, 1, 32'h12348765, 32'h0000_1234, 1'b1});
        vecs.push_back('{32'h00002403, 32'h0000_0004, 32'h0000_012C, 2'd1, 1'b1, 1, 32'hDEADBEEF, 32'hDEAD_BEEF, 1'b1});
        vecs.push_back('{32'h00007483, 32'h0000_0003, 32'h0000_0130, 2'd1, 1'b1, 1, 32'hCAFEF00D, 32'hCAFE_F00D, 1'b1});
        vecs.push_back('{32'h00000533, 32'h0000_55AA, 32'h0000_0134, 2'd3, 1'b1, 0, 32'h0, 32'h0000_55AA, 1'b1});
        vecs.push_back('{32'h00000533, 32'h0000_0099, 32'h0000_0138, 2'd0, 1'b0, 0, 32'h0, 32'h0000_0099, 1'b0});

        foreach (vecs[i]) begin
            applyStimulus(1'b1, vecs[i].inst, vecs[i].alu, vecs[i].pc, vecs[i].sel,
                          vecs[i].wen, 1'b0, 32'h0);
            checkOutput($sformatf("vec%0d_in_ready_accept", i), in_ready, 1'b1);
            tick();
            in_valid = 1'b0;
            if (vecs[i].sel == 2'd1) begin
                checkOutput($sformatf("vec%0d_no_retire_on_accept", i), RegWEn, 1'b0);
                for (int d = 1; d <= vecs[i].delay; d++) begin
                    checkOutput($sformatf("vec%0d_in_ready_wait%0d", i, d), in_ready, 1'b0);
                    mem_rvalid = (d == vecs[i].delay);
                    mem_rdata  = vecs[i].rdata;
                    tick();
                end
                mem_rvalid = 1'b0;
            end
            checkOutput($sformatf("vec%0d_RegWEn", i), RegWEn, vecs[i].exp_wen);
            checkOutput($sformatf("vec%0d_DataD", i), DataD, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_inst_W", i), inst_W, vecs[i].inst);
            checkOutput($sformatf("vec%0d_in_ready_after", i), in_ready, 1'b1);
            tick();
            checkOutput($sformatf("vec%0d_RegWEn_drop", i), RegWEn, 1'b0);
            checkOutput($sformatf("vec%0d_DataD_hold", i), DataD, vecs[i].exp_data);
        end
`ifdef WB_RETIRE_CNT_EN
        checkOutput("table_instret", instret, 64'(vecs.size()));
`endif

        // Reset during WAIT_MEM discards the pending load, and a late response is ignored.
        doReset();
        applyStimulus(1'b1, 32'h00000303, 32'h0000_1003, 32'h0, 2'd1, 1'b1, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("rstwait_in_ready_busy", in_ready, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("rstwait_async_in_ready", in_ready, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80FF1234;
        tick();
        mem_rvalid = 1'b0;
        checkOutput("rstwait_RegWEn", RegWEn, 1'b0);
        checkOutput("rstwait_inst_W", inst_W, 32'h0000_0013);
        checkOutput("rstwait_DataD", DataD, 32'h0);
        checkOutput("rstwait_in_ready", in_ready, 1'b1);

        // Four back-to-back ALU ops then a load.
        doReset();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 32'((i << 7) | 32'h33), 32'(100 + i), 32'h0, 2'd0, 1'b1,
                          1'b0, 32'h0);
            checkOutput($sformatf("b2b_in_ready%0d", i), in_ready, 1'b1);
            tick();
            checkOutput($sformatf("b2b_RegWEn%0d", i), RegWEn, 1'b1);
            checkOutput($sformatf("b2b_DataD%0d", i), DataD, 32'(100 + i));
        end
        applyStimulus(1'b1, 32'h00002403, 32'h0000_0010, 32'h0, 2'd1, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("b2b_load_accept_RegWEn", RegWEn, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h11223344);
        checkOutput("b2b_load_in_ready", in_ready, 1'b0);
        tick();
        mem_rvalid = 1'b0;
        checkOutput("b2b_load_RegWEn", RegWEn, 1'b1);
        checkOutput("b2b_load_DataD", DataD, 32'h11223344);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("b2b_instret", instret, 64'd5);
`endif

        // Randomized traffic against the behavioural model.
        doReset();
        m_busy   = 1'b0;
        m_inst_w = 32'h0000_0013;
        m_data   = 32'h0;
        m_cnt    = 0;
        m_pinst  = 32'h0;
        m_palu   = 32'h0;
        m_pwen   = 1'b0;
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom);
            checkOutput($sformatf("rand%0d_in_ready", c), in_ready, !m_busy);
            m_wen = 1'b0;
            if (!m_busy) begin
                if (in_valid) begin
                    if (wb_sel_M == 2'd1) begin
                        m_busy  = 1'b1;
                        m_pinst = inst_M;
                        m_palu  = alu_M;
                        m_pwen  = reg_wen_M;
                    end else begin
                        m_inst_w = inst_M;
                        m_data   = (wb_sel_M == 2'd2) ? 32'((64'(pc_M) + 4) % 64'h1_0000_0000)
                                                      : alu_M;
                        m_wen    = reg_wen_M && (((inst_M >> 7) % 32) != 0);
                        m_cnt++;
                    end
                end
            end else if (mem_rvalid) begin
                m_busy   = 1'b0;
                m_inst_w = m_pinst;
                m_data   = ref_load(3'((m_pinst >> 12) % 8), m_palu, mem_rdata);
                m_wen    = m_pwen && (((m_pinst >> 7) % 32) != 0);
                m_cnt++;
            end
            tick();
            checkOutput($sformatf("rand%0d_RegWEn", c), RegWEn, m_wen);
            checkOutput($sformatf("rand%0d_inst_W", c), inst_W, m_inst_w);
            checkOutput($sformatf("rand%0d_DataD", c), DataD, m_data);
        end
`ifdef WB_RETIRE_CNT_EN
        checkOutput("rand_instret", instret, m_cnt);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
